dsc_mul_n: RTL and testbench

- Parametrised deterministic-stochastic-computing (DSC) multiplier, clock-division method.
- Takes NUM_INPUTS unsigned NUM_BITS-bit operands and returns their exact product.
- Each operand becomes a unary stream by comparing it against one digit of a shared mixed-radix counter; the streams are ANDed and the 1s are counted.
- Successor to the fixed 3x8b dsc_mul: generic width and input count, start/busy/done handshake, cycle-count output, optional zero-run skipping (SKIP mode).

---
 rtl/dsc_mul_n_pkg.sv | 38 +++
 rtl/dsc_mul_n_if.sv | 41 ++++
 rtl/dsc_mul_n_skip_ctr.sv | 92 +++++++++
 rtl/dsc_mul_n.sv | 113 +++++++++++
 tb/tb_dsc_mul_n.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsc_mul_n_pkg.sv
// -----------------------------------------------------------------------------
// dsc_pkg
// Shared types and helpers for the dsc_mul_n deterministic stochastic
// multiplier.
//   dsc_state_t  : controller state (IDLE / RUN / DONE)
//   tot_bits()   : operand bus / product width  (NUM_INPUTS * NUM_BITS)
//   cyc_bits()   : cycle-counter width          (TOT_BITS + 1)
//   digit_slice(): extracts one counter digit from a (zero-extended) vector
// -----------------------------------------------------------------------------
package dsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dsc_state_t;

  // Widest vector digit_slice() accepts; callers zero-extend to this width.
  localparam int MAX_VEC = 256;

  function automatic int tot_bits(input int num_inputs, input int num_bits);
    return num_inputs * num_bits;
  endfunction

  // One extra bit: SKIP=0 runs exactly 2^TOT_BITS evaluations.
  function automatic int cyc_bits(input int num_inputs, input int num_bits);
    return num_inputs * num_bits + 1;
  endfunction

  function automatic logic [MAX_VEC-1:0] digit_slice(input logic [MAX_VEC-1:0] vec,
                                                     input int idx,
                                                     input int width);
    logic [MAX_VEC-1:0] mask;
    mask = (MAX_VEC'(1) << width) - MAX_VEC'(1);
    return (vec >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/dsc_mul_n_if.sv
// -----------------------------------------------------------------------------
// dsc_mul_n_if
// Request/result bundle of dsc_mul_n.
//   en     : clock enable (low = stall everything)
//   start  : operation request, honoured only in IDLE
//   a      : packed operands, operand i at a[i*NUM_BITS +: NUM_BITS]
//   busy   : operation in progress
//   ov     : one-cycle completion pulse
//   z      : product, valid from ov until the next accepted start
//   cycles : evaluation count of the last operation
// master = requester (drives en/start/a), slave = multiplier.
// -----------------------------------------------------------------------------
interface dsc_mul_n_if
  import dsc_pkg::*;
#(
  parameter int NUM_INPUTS = 3,
  parameter int NUM_BITS   = 8
);

  localparam int TOT_BITS = tot_bits(NUM_INPUTS, NUM_BITS);
  localparam int CYC_BITS = cyc_bits(NUM_INPUTS, NUM_BITS);

  logic                en;
  logic                start;
  logic [TOT_BITS-1:0] a;
  logic                busy;
  logic                ov;
  logic [TOT_BITS-1:0] z;
  logic [CYC_BITS-1:0] cycles;

  modport master (
    output en, start, a,
    input  busy, ov, z, cycles
  );

  modport slave (
    input  en, start, a,
    output busy, ov, z, cycles
  );

endinterface

// File: rtl/dsc_mul_n_skip_ctr.sv
// -----------------------------------------------------------------------------
// dsc_skip_ctr
// Mixed-radix counter (NUM_INPUTS digits of NUM_BITS) and comparator bank.
// Each operand is compared against its own digit to form a unary stream bit;
// the AND of all stream bits is the product contribution of this evaluation.
//   clk, rst     : clock, asynchronous active-low reset
//   i_en         : clock enable
//   i_clr        : clear the counter (start of an operation)
//   i_inc        : advance the counter by one evaluation step
//   i_ops        : latched operands, operand 0 drives the fastest digit
//   o_and_bit    : AND of all stream bits for the current counter value
//   o_carry_out  : this step wraps past the top digit (operation complete)
// With SKIP=1, when some stream bit k is 0 every remaining value of digit k
// (and any lower digits) also yields 0, so the step jumps straight to the next
// value of digit k+1: digits 0..k are cleared and digit k+1 is incremented.
// The highest such k gives the largest safe jump.
// -----------------------------------------------------------------------------
module dsc_skip_ctr
  import dsc_pkg::*;
#(
  parameter  int NUM_INPUTS = 3,
  parameter  int NUM_BITS   = 8,
  parameter  int SKIP       = 1,
  localparam int TOT_BITS   = NUM_INPUTS * NUM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic                i_inc,
  input  logic [TOT_BITS-1:0] i_ops,
  output logic                o_and_bit,
  output logic                o_carry_out
);

  logic [TOT_BITS-1:0]   r_ctr;
  logic [NUM_INPUTS-1:0] w_stream;
  // Per-digit jump amount (1 << (k+1)*B) and mask keeping digits above k.
  logic [TOT_BITS:0]     w_step_tab [NUM_INPUTS];
  logic [TOT_BITS-1:0]   w_keep_tab [NUM_INPUTS];
  logic [TOT_BITS-1:0]   w_base;
  logic [TOT_BITS:0]     w_step;
  logic [TOT_BITS:0]     w_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_digit
      logic [NUM_BITS-1:0] w_digit;
      logic [NUM_BITS-1:0] w_op;

      assign w_digit      = NUM_BITS'(digit_slice(MAX_VEC'(r_ctr), gi, NUM_BITS));
      assign w_op         = i_ops[gi*NUM_BITS +: NUM_BITS];
      assign w_stream[gi] = (w_op > w_digit);

      assign w_step_tab[gi] = (TOT_BITS+1)'(1) << ((gi + 1) * NUM_BITS);
      // For the top digit the step's low bits are zero, so the mask is zero.
      assign w_keep_tab[gi] = ~(w_step_tab[gi][TOT_BITS-1:0] - TOT_BITS'(1));
    end
  endgenerate

  assign o_and_bit = &w_stream;

  // Ascending scan: the last zero stream bit found (highest index) wins.
  always_comb begin
    w_base = r_ctr;
    w_step = (TOT_BITS+1)'(1);
    if (SKIP != 0) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (!w_stream[i]) begin
          w_base = r_ctr & w_keep_tab[i];
          w_step = w_step_tab[i];
        end
      end
    end
  end

  assign w_sum       = {1'b0, w_base} + w_step;
  assign o_carry_out = w_sum[TOT_BITS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctr <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_ctr <= '0;
      end else if (i_inc) begin
        r_ctr <= w_sum[TOT_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/dsc_mul_n.sv
// -----------------------------------------------------------------------------
// dsc_mul_n
// Deterministic stochastic-computing multiplier (clock-division method).
// Returns the exact product of NUM_INPUTS unsigned NUM_BITS-bit operands by
// counting the cycles in which all unary operand streams are 1.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : dsc_mul_n_if slave (en, start, a -> busy, ov, z, cycles)
// Parameters: NUM_INPUTS (>=2), NUM_BITS, SKIP (0 exhaustive, 1 zero-run skip).
// Flow: IDLE --start--> RUN (one evaluation per enabled cycle) --carry-->
// DONE (one-cycle ov) --> IDLE.  Every register holds while en is low; ov is
// qualified by en so the pulse appears on the first enabled DONE cycle only.
// -----------------------------------------------------------------------------
module dsc_mul_n
  import dsc_pkg::*;
#(
  parameter int NUM_INPUTS = 3,
  parameter int NUM_BITS   = 8,
  parameter int SKIP       = 1
) (
  input logic        clk,
  input logic        rst,
  dsc_mul_n_if.slave bus
);

  localparam int TOT_BITS = tot_bits(NUM_INPUTS, NUM_BITS);
  localparam int CYC_BITS = cyc_bits(NUM_INPUTS, NUM_BITS);

  dsc_state_t          r_state;
  dsc_state_t          w_state_next;
  logic [TOT_BITS-1:0] r_ops;
  logic [TOT_BITS-1:0] r_z;
  logic [CYC_BITS-1:0] r_cycles;
  logic                w_accept;
  logic                w_eval;
  logic                w_and_bit;
  logic                w_carry;

  dsc_skip_ctr #(
    .NUM_INPUTS (NUM_INPUTS),
    .NUM_BITS   (NUM_BITS),
    .SKIP       (SKIP)
  ) u_ctr (
    .clk         (clk),
    .rst         (rst),
    .i_en        (bus.en),
    .i_clr       (w_accept),
    .i_inc       (w_eval),
    .i_ops       (r_ops),
    .o_and_bit   (w_and_bit),
    .o_carry_out (w_carry)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_eval       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_eval = 1'b1;
        if (w_carry) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else if (bus.en) begin
      r_state <= w_state_next;
    end
  end

  // Operand latch, product accumulator and evaluation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ops    <= '0;
      r_z      <= '0;
      r_cycles <= '0;
    end else if (bus.en) begin
      if (w_accept) begin
        r_ops    <= bus.a;
        r_z      <= '0;
        r_cycles <= '0;
      end else if (w_eval) begin
        r_cycles <= r_cycles + CYC_BITS'(1);
        if (w_and_bit) begin
          r_z <= r_z + TOT_BITS'(1);
        end
      end
    end
  end

  assign bus.busy   = (r_state == ST_RUN);
  assign bus.ov     = (r_state == ST_DONE) && bus.en;
  assign bus.z      = r_z;
  assign bus.cycles = r_cycles;

endmodule

// File: tb/tb_dsc_mul_n.sv
// -----------------------------------------------------------------------------
// tb_dsc_mul_n
// Three multiplier instances:
//   u_dut0 : N=2, B=4, SKIP=0
//   u_dut1 : N=3, B=8, SKIP=1
//   u_dut2 : N=3, B=4, SKIP=1 (all-max / zero-fast-digit / random runs that
//            stay short enough to simulate)
// Expected products and cycle counts come from plain arithmetic on operands.
// -----------------------------------------------------------------------------
module tb_dsc_mul_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsc_mul_n_if #(.NUM_INPUTS(2), .NUM_BITS(4)) if0 ();
  dsc_mul_n_if #(.NUM_INPUTS(3), .NUM_BITS(8)) if1 ();
  dsc_mul_n_if #(.NUM_INPUTS(3), .NUM_BITS(4)) if2 ();

  dsc_mul_n #(.NUM_INPUTS(2), .NUM_BITS(4), .SKIP(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  dsc_mul_n #(.NUM_INPUTS(3), .NUM_BITS(8), .SKIP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  dsc_mul_n #(.NUM_INPUTS(3), .NUM_BITS(4), .SKIP(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  function automatic longint model_product(input int ops[3], input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * ops[i];
    return p;
  endfunction

  // Exhaustive: every counter value once. Skipping: one cycle per product
  // term plus one per skipped run at each level (suffix products).
  function automatic longint model_cycles(input int ops[3], input int n, input int b, input bit skip);
    longint total;
    longint p;
    if (!skip) return longint'(1) << (n * b);
    total = 0;
    for (int j = 0; j <= n; j++) begin
      p = 1;
      for (int i = j; i < n; i++) p = p * ops[i];
      total = total + p;
    end
    return total;
  endfunction

  // ---------------- drivers ----------------
  task automatic run0(input logic [7:0] a, input int limit, output int lat);
    @(negedge clk);
    if0.a = a; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    lat = 1;
    while (if0.ov !== 1'b1 && lat <= limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run1(input logic [23:0] a, input int limit, output int lat, output int busy_n);
    @(negedge clk);
    if1.a = a; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    lat = 1; busy_n = 0;
    while (if1.ov !== 1'b1 && lat <= limit) begin
      if (if1.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Optionally drops en for stall_n single cycles at random points mid-run.
  task automatic run2(input logic [11:0] a, input int stall_n, input int limit, output int lat);
    int gap;
    int left;
    @(negedge clk);
    if2.a = a; if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    lat = 1; left = stall_n; gap = int'($urandom_range(100, 400));
    while (if2.ov !== 1'b1 && lat <= limit) begin
      if (left > 0 && gap == 0 && if2.busy === 1'b1) begin
        if2.en = 1'b0; left--; gap = int'($urandom_range(1, 20));
      end else begin
        if2.en = 1'b1;
        if (gap > 0) gap--;
      end
      @(negedge clk);
      lat++;
    end
    if2.en = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    if0.en = 1'b1; if0.start = 1'b0; if0.a = '0;
    if1.en = 1'b1; if1.start = 1'b0; if1.a = '0;
    if2.en = 1'b1; if2.start = 1'b0; if2.a = '0;
    repeat (3) @(negedge clk);
    vectors++; if ({if0.busy, if0.ov} !== 2'b00) begin miscompares++; $display("FAIL reset0_flags: got %b expected 00", {if0.busy, if0.ov}); end
    vectors++; if (if0.z !== '0) begin miscompares++; $display("FAIL reset0_z: got %0d expected 0", if0.z); end
    vectors++; if (if0.cycles !== '0) begin miscompares++; $display("FAIL reset0_cycles: got %0d expected 0", if0.cycles); end
    vectors++; if ({if1.busy, if1.ov} !== 2'b00) begin miscompares++; $display("FAIL reset1_flags: got %b expected 00", {if1.busy, if1.ov}); end
    vectors++; if (if1.z !== '0) begin miscompares++; $display("FAIL reset1_z: got %0d expected 0", if1.z); end
    vectors++; if (if1.cycles !== '0) begin miscompares++; $display("FAIL reset1_cycles: got %0d expected 0", if1.cycles); end
    vectors++; if ({if2.busy, if2.ov} !== 2'b00) begin miscompares++; $display("FAIL reset2_flags: got %b expected 00", {if2.busy, if2.ov}); end
    vectors++; if (if2.z !== '0) begin miscompares++; $display("FAIL reset2_z: got %0d expected 0", if2.z); end
    vectors++; if (if2.cycles !== '0) begin miscompares++; $display("FAIL reset2_cycles: got %0d expected 0", if2.cycles); end
    rst = 1'b1;
    $display("reset: all outputs sampled");
  endtask

  task automatic test_exhaustive();
    int lat;
    run0({4'd3, 4'd5}, 300, lat);
    $display("u0 a=(5,3) z=%0d cycles=%0d lat=%0d", if0.z, if0.cycles, lat);
    vectors++; if (lat != 257) begin miscompares++; $display("FAIL exh_latency: got %0d expected 257", lat); end
    vectors++; if (64'(if0.z) !== 64'd15) begin miscompares++; $display("FAIL exh_z: got %0d expected 15", if0.z); end
    vectors++; if (64'(if0.cycles) !== 64'd256) begin miscompares++; $display("FAIL exh_cycles: got %0d expected 256", if0.cycles); end
    @(negedge clk);
    vectors++; if (if0.ov !== 1'b0) begin miscompares++; $display("FAIL exh_ov_pulse: got %b expected 0", if0.ov); end
  endtask

  task automatic test_skip_basic();
    int lat;
    int busy_n;
    run1({8'd1, 8'd3, 8'd2}, 50, lat, busy_n);
    $display("u1 a=(2,3,1) z=%0d cycles=%0d lat=%0d busy=%0d", if1.z, if1.cycles, lat, busy_n);
    vectors++; if (64'(if1.z) !== 64'd6) begin miscompares++; $display("FAIL skip_z: got %0d expected 6", if1.z); end
    vectors++; if (64'(if1.cycles) !== 64'd11) begin miscompares++; $display("FAIL skip_cycles: got %0d expected 11", if1.cycles); end
    vectors++; if (lat != 12) begin miscompares++; $display("FAIL skip_latency: got %0d expected 12", lat); end
    vectors++; if (busy_n != 11) begin miscompares++; $display("FAIL skip_busy_len: got %0d expected 11", busy_n); end
    vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL skip_busy_at_ov: got %b expected 0", if1.busy); end
    @(negedge clk);
    vectors++; if (if1.ov !== 1'b0) begin miscompares++; $display("FAIL skip_ov_pulse: got %b expected 0", if1.ov); end
  endtask

  task automatic test_boundaries();
    int lat;
    int busy_n;
    run1({8'd0, 8'd255, 8'd255}, 10, lat, busy_n);
    $display("u1 a=(255,255,0) z=%0d cycles=%0d lat=%0d", if1.z, if1.cycles, lat);
    vectors++; if (64'(if1.z) !== 64'd0) begin miscompares++; $display("FAIL top_zero_z: got %0d expected 0", if1.z); end
    vectors++; if (64'(if1.cycles) !== 64'd1) begin miscompares++; $display("FAIL top_zero_cycles: got %0d expected 1", if1.cycles); end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL top_zero_latency: got %0d expected 2", lat); end
    run2({4'd15, 4'd15, 4'd0}, 0, 300, lat);
    $display("u2 a=(0,15,15) z=%0d cycles=%0d lat=%0d", if2.z, if2.cycles, lat);
    vectors++; if (64'(if2.z) !== 64'd0) begin miscompares++; $display("FAIL low_zero_z: got %0d expected 0", if2.z); end
    vectors++; if (64'(if2.cycles) !== 64'd241) begin miscompares++; $display("FAIL low_zero_cycles: got %0d expected 241", if2.cycles); end
  endtask

  task automatic test_stall();
    int lat_free;
    int lat_stall;
    run2({4'd15, 4'd15, 4'd15}, 0, 4000, lat_free);
    $display("u2 a=(15,15,15) z=%0d cycles=%0d lat=%0d", if2.z, if2.cycles, lat_free);
    vectors++; if (64'(if2.z) !== 64'd3375) begin miscompares++; $display("FAIL max_z: got %0d expected 3375", if2.z); end
    vectors++; if (64'(if2.cycles) !== 64'd3616) begin miscompares++; $display("FAIL max_cycles: got %0d expected 3616", if2.cycles); end
    vectors++; if (lat_free != 3617) begin miscompares++; $display("FAIL max_latency: got %0d expected 3617", lat_free); end
    run2({4'd15, 4'd15, 4'd15}, 50, 4100, lat_stall);
    $display("u2 a=(15,15,15) stalled z=%0d cycles=%0d lat=%0d", if2.z, if2.cycles, lat_stall);
    vectors++; if (64'(if2.z) !== 64'd3375) begin miscompares++; $display("FAIL stall_z: got %0d expected 3375", if2.z); end
    vectors++; if (64'(if2.cycles) !== 64'd3616) begin miscompares++; $display("FAIL stall_cycles: got %0d expected 3616", if2.cycles); end
    vectors++; if (lat_stall != 3667) begin miscompares++; $display("FAIL stall_latency: got %0d expected 3667", lat_stall); end
    @(negedge clk);
    vectors++; if (if2.ov !== 1'b0) begin miscompares++; $display("FAIL stall_ov_pulse: got %b expected 0", if2.ov); end
  endtask

  task automatic test_start_ignored_and_abort();
    int lat;
    int busy_n;
    // Part A: restart attempt mid-run and during DONE must not disturb the result.
    @(negedge clk);
    if1.a = {8'd4, 8'd9, 8'd7}; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    lat = 1;
    while (if1.ov !== 1'b1 && lat <= 400) begin
      if (lat == 5) begin
        if1.a = {8'd1, 8'd1, 8'd1}; if1.start = 1'b1;
      end else begin
        if1.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    $display("u1 a=(7,9,4) restart-ignored z=%0d cycles=%0d lat=%0d", if1.z, if1.cycles, lat);
    vectors++; if (64'(if1.z) !== 64'd252) begin miscompares++; $display("FAIL ignore_z: got %0d expected 252", if1.z); end
    vectors++; if (64'(if1.cycles) !== 64'd293) begin miscompares++; $display("FAIL ignore_cycles: got %0d expected 293", if1.cycles); end
    vectors++; if (lat != 294) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 294", lat); end
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL done_start_busy: got %b expected 0", if1.busy); end
    @(negedge clk);
    vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL done_start_idle: got %b expected 0", if1.busy); end
    vectors++; if (64'(if1.z) !== 64'd252) begin miscompares++; $display("FAIL done_start_z: got %0d expected 252", if1.z); end
    // Part B: abort by reset, then prove the block accepts a fresh start.
    if1.a = {8'd4, 8'd9, 8'd7}; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    repeat (4) @(negedge clk);
    if1.a = {8'd1, 8'd1, 8'd1}; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (if1.busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy: got %b expected 1", if1.busy); end
    rst = 1'b0;
    #1;
    $display("u1 reset mid-run busy=%b ov=%b z=%0d cycles=%0d", if1.busy, if1.ov, if1.z, if1.cycles);
    vectors++; if ({if1.busy, if1.ov} !== 2'b00) begin miscompares++; $display("FAIL abort_flags: got %b expected 00", {if1.busy, if1.ov}); end
    vectors++; if (if1.z !== '0) begin miscompares++; $display("FAIL abort_z: got %0d expected 0", if1.z); end
    vectors++; if (if1.cycles !== '0) begin miscompares++; $display("FAIL abort_cycles: got %0d expected 0", if1.cycles); end
    @(negedge clk);
    rst = 1'b1;
    run1({8'd1, 8'd1, 8'd1}, 20, lat, busy_n);
    $display("u1 a=(1,1,1) z=%0d cycles=%0d lat=%0d", if1.z, if1.cycles, lat);
    vectors++; if (64'(if1.z) !== 64'd1) begin miscompares++; $display("FAIL post_abort_z: got %0d expected 1", if1.z); end
    vectors++; if (64'(if1.cycles) !== 64'd4) begin miscompares++; $display("FAIL post_abort_cycles: got %0d expected 4", if1.cycles); end
    vectors++; if (lat != 5) begin miscompares++; $display("FAIL post_abort_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_random();
    fork
      begin : p_exhaustive
        int ops[3];
        int lat;
        longint ez;
        longint ec;
        for (int t = 0; t < 100; t++) begin
          ops[0] = int'($urandom_range(0, 15));
          ops[1] = int'($urandom_range(0, 15));
          ops[2] = 0;
          ez = model_product(ops, 2);
          ec = model_cycles(ops, 2, 4, 1'b0);
          run0({4'(ops[1]), 4'(ops[0])}, int'(ec) + 10, lat);
          $display("u0 rnd a=(%0d,%0d) z=%0d cycles=%0d lat=%0d", ops[0], ops[1], if0.z, if0.cycles, lat);
          vectors++; if (64'(if0.z) !== 64'(ez)) begin miscompares++; $display("FAIL rnd0_z: got %0d expected %0d", if0.z, ez); end
          vectors++; if (64'(if0.cycles) !== 64'(ec)) begin miscompares++; $display("FAIL rnd0_cycles: got %0d expected %0d", if0.cycles, ec); end
          vectors++; if (longint'(lat) != ec + 1) begin miscompares++; $display("FAIL rnd0_latency: got %0d expected %0d", lat, ec + 1); end
        end
      end
      begin : p_skipping
        int ops[3];
        int lat;
        longint ez;
        longint ec;
        for (int t = 0; t < 100; t++) begin
          for (int i = 0; i < 3; i++) ops[i] = int'($urandom_range(0, 15));
          ez = model_product(ops, 3);
          ec = model_cycles(ops, 3, 4, 1'b1);
          run2({4'(ops[2]), 4'(ops[1]), 4'(ops[0])}, 0, int'(ec) + 10, lat);
          $display("u2 rnd a=(%0d,%0d,%0d) z=%0d cycles=%0d lat=%0d", ops[0], ops[1], ops[2], if2.z, if2.cycles, lat);
          vectors++; if (64'(if2.z) !== 64'(ez)) begin miscompares++; $display("FAIL rnd2_z: got %0d expected %0d", if2.z, ez); end
          vectors++; if (64'(if2.cycles) !== 64'(ec)) begin miscompares++; $display("FAIL rnd2_cycles: got %0d expected %0d", if2.cycles, ec); end
          vectors++; if (longint'(lat) != ec + 1) begin miscompares++; $display("FAIL rnd2_latency: got %0d expected %0d", lat, ec + 1); end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_skip_basic();
    test_boundaries();
    test_stall();
    test_start_ignored_and_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
